// File: rtl/constants.sv
// Global core constants shared by every pipeline stage of the 16-bit core.
package constants;
  localparam int WORD_LEN = 16;
endpackage

// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch controller state encoding and PC step.
package cpu_pkg;
  import constants::*;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BRANCH = 2'd2,
    HALT   = 2'd3
  } fetch_state_t;

  localparam logic [WORD_LEN-1:0] PC_STEP = WORD_LEN'(2);
endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at MAX instead of wrapping; clr has priority over en.
module sat_counter #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing: arbitrates branch, halt and stall requests and
// drives the PC advance/branch-load controls plus fetch counter and watchdog.
module fetch_ctrl
  import constants::*;
  import cpu_pkg::*;
#(
  parameter int STALL_MAX = 8,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                stall_req,
  input  logic                br_req,
  input  logic [WORD_LEN-1:0] br_target,
  input  logic                halt_req,
  input  logic                resume,
  output logic                IncreaseTK,
  output logic                BranchTK,
  output logic [WORD_LEN-1:0] Broffset,
  output logic                flush,
  output logic                halted,
  output logic [CNT_W-1:0]    fetch_count,
  output logic                stall_err,
  output logic                addr_err
);

  localparam int              WD_W    = $clog2(STALL_MAX + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(STALL_MAX);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_MAX - 1);

  fetch_state_t        state_q, state_d;
  logic [WORD_LEN-1:0] broff_q, broff_d;
  logic                addr_err_q, addr_err_d;
  logic                stall_err_q, stall_err_d;
  logic                wd_en, wd_at_max, fc_en, fc_at_max;
  logic [WD_W-1:0]     wd_count;

  always_comb begin
    state_d    = state_q;
    broff_d    = broff_q;
    addr_err_d = addr_err_q;
    IncreaseTK = 1'b0;
    flush      = 1'b1;
    wd_en      = 1'b0;
    unique case (state_q)
      BOOT:   state_d = RUN;
      BRANCH: state_d = RUN;
      HALT:   if (resume) state_d = RUN;
      RUN: begin
        if (br_req) begin
          state_d    = BRANCH;
          broff_d    = {br_target[WORD_LEN-1:1], 1'b0};
          addr_err_d = addr_err_q | br_target[0];
        end else if (halt_req) begin
          state_d = HALT;
        end else if (stall_req) begin
          flush = 1'b0;
          wd_en = 1'b1;
        end else begin
          flush      = 1'b0;
          IncreaseTK = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // The flag sets on the same edge the consecutive-stall count reaches STALL_MAX.
  assign stall_err_d = stall_err_q | wd_at_max | (wd_en && (wd_count == WD_LAST));
  assign fc_en       = (state_q == RUN) && !flush && !fc_at_max;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= BOOT;
      broff_q     <= '0;
      addr_err_q  <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      broff_q     <= broff_d;
      addr_err_q  <= addr_err_d;
      stall_err_q <= stall_err_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   ({CNT_W{1'b1}})
  ) u_fetch_cnt (
    .clk    (clk),
    .nReset (nReset),
    .en     (fc_en),
    .clr    (1'b0),
    .count  (fetch_count),
    .at_max (fc_at_max)
  );

  sat_counter #(
    .WIDTH (WD_W),
    .MAX   (WD_MAX)
  ) u_watchdog (
    .clk    (clk),
    .nReset (nReset),
    .en     (wd_en),
    .clr    (!wd_en),
    .count  (wd_count),
    .at_max (wd_at_max)
  );

  assign BranchTK  = (state_q == BRANCH);
  assign halted    = (state_q == HALT);
  assign Broffset  = broff_q;
  assign stall_err = stall_err_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a cycle-level reference model.
module tb_fetch_ctrl;
  import constants::*;
  import cpu_pkg::*;

  localparam int SMAX    = 8;
  localparam int CNT_MAX = 65535;

  logic                clk = 1'b0;
  logic                nReset = 1'b0;
  logic                stall_req = 1'b0, br_req = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [WORD_LEN-1:0] br_target = '0;
  logic                IncreaseTK, BranchTK, flush, halted, stall_err, addr_err;
  logic [WORD_LEN-1:0] Broffset;
  logic [15:0]         fetch_count;

  logic                nReset2 = 1'b0;
  logic                inc2, btk2, flush2, halted2, serr2, aerr2;
  logic [WORD_LEN-1:0] broff2;
  logic [3:0]          fcnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.STALL_MAX(SMAX), .CNT_W(16)) dut (
    .clk(clk), .nReset(nReset), .stall_req(stall_req), .br_req(br_req),
    .br_target(br_target), .halt_req(halt_req), .resume(resume),
    .IncreaseTK(IncreaseTK), .BranchTK(BranchTK), .Broffset(Broffset),
    .flush(flush), .halted(halted), .fetch_count(fetch_count),
    .stall_err(stall_err), .addr_err(addr_err)
  );

  fetch_ctrl #(.STALL_MAX(SMAX), .CNT_W(4)) dut4 (
    .clk(clk), .nReset(nReset2), .stall_req(1'b0), .br_req(1'b0),
    .br_target('0), .halt_req(1'b0), .resume(1'b0),
    .IncreaseTK(inc2), .BranchTK(btk2), .Broffset(broff2),
    .flush(flush2), .halted(halted2), .fetch_count(fcnt2),
    .stall_err(serr2), .addr_err(aerr2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: boot/branch-pending/halted phases, anything else is normal running.
  bit                  m_boot, m_brp, m_halt, m_aerr, m_serr;
  logic [WORD_LEN-1:0] m_broff, m_pc;
  int                  m_cnt, m_stall;

  function automatic bit m_running();
    return !m_boot && !m_brp && !m_halt;
  endfunction

  function automatic bit exp_flush();
    if (!m_running()) return 1'b1;
    return br_req || halt_req;
  endfunction

  function automatic bit exp_inc();
    return m_running() && !br_req && !halt_req && !stall_req;
  endfunction

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_boot <= 1'b1; m_brp <= 1'b0; m_halt <= 1'b0; m_aerr <= 1'b0; m_serr <= 1'b0;
      m_broff <= '0; m_pc <= '0; m_cnt <= 0; m_stall <= 0;
    end else if (m_boot) begin
      m_boot <= 1'b0; m_stall <= 0;
    end else if (m_brp) begin
      m_brp <= 1'b0; m_pc <= m_broff; m_stall <= 0;
    end else if (m_halt) begin
      if (resume) m_halt <= 1'b0;
      m_stall <= 0;
    end else begin
      if (!exp_flush()) m_cnt <= (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
      if (br_req) begin
        m_brp   <= 1'b1;
        m_broff <= br_target & ~16'h0001;
        if (br_target[0]) m_aerr <= 1'b1;
        m_stall <= 0;
      end else if (halt_req) begin
        m_halt  <= 1'b1;
        m_stall <= 0;
      end else if (stall_req) begin
        m_stall <= (m_stall >= SMAX) ? SMAX : m_stall + 1;
        if (m_stall + 1 >= SMAX) m_serr <= 1'b1;
      end else begin
        m_pc    <= m_pc + PC_STEP;
        m_stall <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("flush",       32'(flush),       32'(exp_flush()));
    chk("IncreaseTK",  32'(IncreaseTK),  32'(exp_inc()));
    chk("BranchTK",    32'(BranchTK),    32'(m_brp));
    chk("halted",      32'(halted),      32'(m_halt));
    chk("Broffset",    32'(Broffset),    32'(m_broff));
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    chk("stall_err",   32'(stall_err),   32'(m_serr));
    chk("addr_err",    32'(addr_err),    32'(m_aerr));
    if (IncreaseTK && BranchTK) chk("inc_and_branch", 32'(1), 32'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_flush", 32'(flush), 32'(1));
    chk("rst_inc", 32'(IncreaseTK), 32'(0));
    step();
    chk("rst_broff", 32'(Broffset), 32'(0));
    chk("rst_cnt", 32'(fetch_count), 32'(0));
    chk("rst_halted", 32'(halted), 32'(0));
    nReset = 1'b1;
    nReset2 = 1'b1;
    #1;
    chk("boot_flush", 32'(flush), 32'(1));
    chk("boot_inc", 32'(IncreaseTK), 32'(0));
    step();
    chk("run_inc", 32'(IncreaseTK), 32'(1));
    repeat (10) step();
    chk("cnt_10", 32'(fetch_count), 32'(10));

    br_req = 1'b1; br_target = 16'h0040; #1;
    chk("br_flush", 32'(flush), 32'(1));
    chk("br_inc", 32'(IncreaseTK), 32'(0));
    step(); br_req = 1'b0;
    chk("br_btk", 32'(BranchTK), 32'(1));
    chk("br_off", 32'(Broffset), 32'(16'h0040));
    step();
    chk("br_done_flush", 32'(flush), 32'(0));
    chk("model_pc_tgt", 32'(m_pc), 32'(16'h0040));

    br_req = 1'b1; halt_req = 1'b1; br_target = 16'h0041;
    step(); br_req = 1'b0; halt_req = 1'b0;
    chk("odd_btk", 32'(BranchTK), 32'(1));
    chk("odd_halted", 32'(halted), 32'(0));
    chk("odd_off", 32'(Broffset), 32'(16'h0040));
    chk("odd_aerr", 32'(addr_err), 32'(1));
    step();
    chk("odd_no_halt", 32'(halted), 32'(0));
    chk("odd_run_inc", 32'(IncreaseTK), 32'(1));

    halt_req = 1'b1; #1;
    chk("halt_req_flush", 32'(flush), 32'(1));
    step(); halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      br_req = (i == 2); br_target = 16'h0080;
      resume = (i == 4);
      #1;
      chk("halt_h", 32'(halted), 32'(1));
      chk("halt_inc", 32'(IncreaseTK), 32'(0));
      step();
    end
    br_req = 1'b0; resume = 1'b0;
    chk("resume_halted", 32'(halted), 32'(0));
    chk("resume_inc", 32'(IncreaseTK), 32'(1));
    chk("resume_no_br", 32'(BranchTK), 32'(0));
    chk("resume_off", 32'(Broffset), 32'(16'h0040));

    stall_req = 1'b1;
    repeat (7) step();
    stall_req = 1'b0;
    chk("wd_7", 32'(stall_err), 32'(0));
    step();
    stall_req = 1'b1;
    repeat (8) step();
    stall_req = 1'b0;
    chk("wd_8", 32'(stall_err), 32'(1));
    repeat (3) step();
    chk("wd_sticky", 32'(stall_err), 32'(1));

    nReset2 = 1'b0;
    step();
    nReset2 = 1'b1;
    repeat (15) step();
    chk("sat_14", 32'(fcnt2), 32'(14));
    repeat (6) step();
    chk("sat_15", 32'(fcnt2), 32'(15));

    br_req = 1'b1; br_target = 16'h1234;
    step(); br_req = 1'b0;
    chk("pre_rst_btk", 32'(BranchTK), 32'(1));
    #2 nReset = 1'b0;
    #1;
    chk("arst_btk", 32'(BranchTK), 32'(0));
    chk("arst_off", 32'(Broffset), 32'(0));
    chk("arst_flush", 32'(flush), 32'(1));
    chk("arst_inc", 32'(IncreaseTK), 32'(0));
    chk("arst_cnt", 32'(fetch_count), 32'(0));
    chk("arst_serr", 32'(stall_err), 32'(0));
    chk("arst_aerr", 32'(addr_err), 32'(0));
    step();
    nReset = 1'b1;
    repeat (3) step();
    chk("post_rst_cnt", 32'(fetch_count), 32'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage of the 16-bit three-stage core. It drives the fetch stage's PC-advance (`IncreaseTK`), branch-load (`BranchTK`) and branch-target (`Broffset`) controls. It also tells the IF/ID register when to load a bubble (`flush`). It arbitrates branch redirects from the execute stage, halts, and hazard stalls from decode, and keeps a fetch counter and a stall watchdog.

## Interface
Parameters:
- `STALL_MAX`, default 8: consecutive stalled cycles that trip `stall_err`.
- `CNT_W`, default 16: width of `fetch_count`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `nReset` in 1: reset is asynchronous and active-low.
- `stall_req` in 1: decode hazard; hold the PC this cycle.
- `br_req` in 1: execute stage resolved a taken branch this cycle.
- `br_target` in `WORD_LEN`: branch destination, valid with `br_req`.
- `halt_req` in 1: HALT instruction decoded.
- `resume` in 1: leave HALT.
- `IncreaseTK` out 1: PC advances by 2 at the next edge.
- `BranchTK` out 1: PC loads `Broffset` at the next edge.
- `Broffset` out `WORD_LEN`: registered branch target.
- `flush` out 1: the instruction fetched this cycle is invalid; IF/ID loads a bubble.
- `halted` out 1: controller is in HALT.
- `fetch_count` out `CNT_W`: valid instructions fetched, saturating.
- `stall_err` out 1: sticky watchdog flag.
- `addr_err` out 1: sticky flag for an odd branch target.

## Operation
FSM states are BOOT, RUN, BRANCH and HALT.
- **BOOT** (entered on reset):
  - Outputs: `IncreaseTK`=0, `BranchTK`=0, `flush`=1.
  - Transition: always goes to RUN after 1 cycle.
  - Purpose: the instruction memory gets one cycle at address 0.
- **RUN**: request priority is `br_req` > `halt_req` > `stall_req`.
  - `br_req`=1:
    - Outputs: `IncreaseTK`=0, `flush`=1 (Mealy).
    - Register updates: `Broffset` <= `{br_target[WORD_LEN-1:1],1'b0}`; if `br_target[0]`=1, set `addr_err`.
    - Next state: BRANCH.
  - else `halt_req`=1:
    - Outputs: `IncreaseTK`=0, `flush`=1 (the HALT word itself is not re-fetched).
    - Next state: HALT.
  - else `stall_req`=1: `IncreaseTK`=0, `flush`=0; stay in RUN.
  - else: `IncreaseTK`=1, `flush`=0.
- **BRANCH**:
  - Outputs: `BranchTK`=1, `IncreaseTK`=0, `flush`=1.
  - Inputs: `br_req`, `halt_req` and `stall_req` are ignored this cycle.
  - Transition: goes to RUN.
- **HALT**:
  - Outputs: `halted`=1, `IncreaseTK`=0, `BranchTK`=0, `flush`=1.
  - Inputs: `br_req`, `halt_req` and `stall_req` are ignored.
  - Transition: `resume`=1 goes to RUN on the next cycle.
- **`fetch_count`**:
  - Increments in any cycle where state is RUN and `flush`=0, stalled cycles included.
  - Saturates at all-ones and never wraps.
- **Stall watchdog**:
  - A counter of consecutive RUN cycles with `stall_req`=1 and no `br_req`/`halt_req`.
  - Clears on any other cycle.
  - When it reaches `STALL_MAX`, `stall_err` sets. The flag stays set until reset.
  - The counter saturates at `STALL_MAX`.
- **`BranchTK` and `IncreaseTK`** are never both 1.

## Timing
- **Reset values**:
  - `IncreaseTK`=0, `BranchTK`=0, `Broffset`=0, `flush`=1, `halted`=0.
  - `fetch_count`=0, `stall_err`=0, `addr_err`=0.
  - State is BOOT.
- **Reset mid-operation**: asynchronous and immediate. A captured branch target is discarded and all counters clear.
- **Branch penalty**: 2 bubbles.
  - Cycle N: `br_req` is accepted.
  - Cycle N+1: BRANCH.
  - Cycle N+2: PC equals the target and `flush`=0.
- **Halt**:
  - Cycle N: `halt_req` is accepted.
  - Cycle N+1: `halted`=1.
  - `resume` in cycle M puts the FSM in RUN at M+1, with fetch continuing from the held PC.
- **Simultaneous events**:
  - `br_req` with `halt_req`: the branch wins and the halt is dropped. Decode re-presents it if the HALT is on the taken path.
  - `br_req` with `stall_req`: the branch wins.
- **Signal classes**:
  - `flush` and `IncreaseTK` are combinational from state and inputs.
  - `BranchTK`, `Broffset`, `halted`, the counters and the flags are registered or state-decoded.

## Structure
- The shared package `cpu_pkg` holds:
  - `fetch_state_t`, a 2-bit enum: BOOT=0, RUN=1, BRANCH=2, HALT=3.
  - The PC step constant 2.
- `WORD_LEN` comes from `constants.sv`.
- One sub-module, `sat_counter`, has parameters `WIDTH` and `MAX` and ports `clk`, `nReset`, `en`, `clr`, `count` and `at_max`. It is instantiated twice: for `fetch_count` and for the watchdog.

## Test plan
- **Reset and free run**: release `nReset`, no requests.
  - Cycle 0: BOOT with `flush`=1.
  - Cycle 1 onward: `IncreaseTK`=1.
  - After 10 RUN cycles, `fetch_count`=10.
- **Branch**: `br_req`=1 with `br_target`=16'h0040 in RUN.
  - That cycle: `flush`=1, `IncreaseTK`=0.
  - Next cycle: `BranchTK`=1, `Broffset`=16'h0040.
  - Third cycle: `flush`=0.
- **Odd target and priority**: `br_target`=16'h0041 with `halt_req`=1 in the same cycle.
  - `Broffset`=16'h0040 and `addr_err`=1.
  - State goes to BRANCH, not HALT.
- **Halt and resume**: `halt_req` pulse, then `resume` 5 cycles later.
  - `halted`=1 for 5 cycles and `IncreaseTK`=0 throughout.
  - `br_req` pulsed during HALT is ignored.
  - RUN resumes the cycle after `resume`.
- **Watchdog**: `stall_req` held for 7 cycles gives `stall_err`=0. Held for 8 cycles, `stall_err`=1, and it stays 1 after `stall_req` drops.
- **Saturation and async reset**:
  - With `CNT_W`=4, 20 free-run cycles leave `fetch_count`=15.
  - Dropping `nReset` mid-BRANCH clears all outputs to their reset values without waiting for a clock edge.
